// File: rtl/mor1kx_rf_port_ctrl_latte.sv
// Write-port / SPR side-port controller for the latte register file:
// post-reset zero-fill sweep, write-port arbitration and SPR-bus GPR access.
module mor1kx_rf_port_ctrl_latte #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int RF_ADDR_WIDTH        = 5,
  parameter int CLEAR_ON_RESET       = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_rf_we_i,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wb_result_i,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
  output logic                            rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_waddr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wdat_o,
  output logic                            rf_sre_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_sraddr_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_srdat_i,
  output logic                            init_busy_o
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_ACK
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;

  state_t                    r_state;
  logic [RF_ADDR_WIDTH:0]    r_cnt;
  logic                      r_init_busy;
  logic                      r_ack;
  logic [OPTION_OPERAND_WIDTH-1:0] r_dat;

  logic [RF_ADDR_WIDTH:0]    w_cnt_nxt;
  logic                      w_gpr_hit;
  logic [RF_ADDR_WIDTH-1:0]  w_gpr_idx;
  logic                      w_idle;
  logic                      w_init_wr;
  logic                      w_spr_wr;
  logic                      w_spr_rd;
  logic                      w_unused_addr;

  assign w_cnt_nxt     = r_cnt + {{RF_ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_gpr_hit     = spr_bus_stb_i & (spr_bus_addr_i[15:9] == 7'h2);
  assign w_gpr_idx     = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
  assign w_unused_addr = &{1'b0, spr_bus_addr_i[8:RF_ADDR_WIDTH]};

  assign w_idle    = (r_state == ST_IDLE) & ~rst;
  assign w_init_wr = (r_state == ST_INIT) & ~rst & ~wb_rf_we_i;
  // The mirror RAM is single-ported: any WB write blocks both SPR writes and reads.
  assign w_spr_wr  = w_idle & w_gpr_hit &  spr_bus_we_i & ~wb_rf_we_i;
  assign w_spr_rd  = w_idle & w_gpr_hit & ~spr_bus_we_i & ~wb_rf_we_i;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = wb_rfd_adr_i;
    rf_wdat_o  = wb_result_i;
    if (!rst) begin
      if (wb_rf_we_i) begin
        rf_we_o = 1'b1;
      end else if (w_init_wr) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = r_cnt[RF_ADDR_WIDTH-1:0];
        rf_wdat_o  = '0;
      end else if (w_spr_wr) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = w_gpr_idx;
        rf_wdat_o  = spr_bus_dat_i;
      end
    end
  end

  assign rf_sre_o    = w_spr_rd;
  assign rf_sraddr_o = w_gpr_idx;

  // Read capture happens in RD_WAIT (data valid one cycle after issue); RD_CAP is
  // then the read-acknowledge cycle, so ack lands two cycles after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RST_STATE;
      r_cnt       <= '0;
      r_init_busy <= (CLEAR_ON_RESET != 0);
      r_ack       <= 1'b0;
      r_dat       <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (!wb_rf_we_i) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt[RF_ADDR_WIDTH]) begin
              r_state     <= ST_IDLE;
              r_init_busy <= 1'b0;
            end
          end
        end
        ST_IDLE: begin
          if (w_spr_wr) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end else if (w_spr_rd) begin
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          r_dat   <= rf_srdat_i;
          r_ack   <= 1'b1;
          r_state <= ST_RD_CAP;
        end
        ST_RD_CAP: r_state <= ST_IDLE;
        ST_ACK:    r_state <= ST_IDLE;
        default:   r_state <= RST_STATE;
      endcase
    end
  end

  assign init_busy_o   = r_init_busy;
  assign spr_gpr_ack_o = r_ack;
  assign spr_gpr_dat_o = r_dat;

endmodule

// File: tb/tb_mor1kx_rf_port_ctrl_latte.sv
// Scoreboard bench for mor1kx_rf_port_ctrl_latte: expected RF writes, read
// issues and acks are queued at stimulus time and retired by a monitor.
module tb_mor1kx_rf_port_ctrl_latte;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_rf_we_i = 1'b0;
  logic [AW-1:0] wb_rfd_adr_i = '0;
  logic [DW-1:0] wb_result_i = '0;
  logic [15:0]   spr_bus_addr_i = '0;
  logic          spr_bus_stb_i = 1'b0;
  logic          spr_bus_we_i = 1'b0;
  logic [DW-1:0] spr_bus_dat_i = '0;
  logic          spr_gpr_ack_o;
  logic [DW-1:0] spr_gpr_dat_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdat_o;
  logic          rf_sre_o;
  logic [AW-1:0] rf_sraddr_o;
  logic [DW-1:0] rf_srdat_i = '0;
  logic          init_busy_o;

  mor1kx_rf_port_ctrl_latte #(
    .OPTION_OPERAND_WIDTH(DW),
    .RF_ADDR_WIDTH(AW),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_rf_we_i(wb_rf_we_i), .wb_rfd_adr_i(wb_rfd_adr_i), .wb_result_i(wb_result_i),
    .spr_bus_addr_i(spr_bus_addr_i), .spr_bus_stb_i(spr_bus_stb_i),
    .spr_bus_we_i(spr_bus_we_i), .spr_bus_dat_i(spr_bus_dat_i),
    .spr_gpr_ack_o(spr_gpr_ack_o), .spr_gpr_dat_o(spr_gpr_dat_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdat_o(rf_wdat_o),
    .rf_sre_o(rf_sre_o), .rf_sraddr_o(rf_sraddr_o), .rf_srdat_i(rf_srdat_i),
    .init_busy_o(init_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { int cyc; logic [AW-1:0] a; } rd_t;
  typedef struct packed { int cyc; logic rd; logic [DW-1:0] d; } ack_t;

  wr_t  q_wr[$];
  rd_t  q_rd[$];
  ack_t q_ack[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port mirror RAM: read data one cycle after the enable.
  always @(posedge clk) begin
    if (rf_we_o) mem[rf_waddr_o] <= rf_wdat_o;
    if (rf_sre_o) rf_srdat_i <= mem[rf_sraddr_o];
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t w; rd_t r; ack_t k;
    if (rf_we_o) begin
      if (q_wr.size() == 0) chk("wr_unexpected", {27'd0, rf_waddr_o}, 32'hFFFF_FFFF);
      else begin
        w = q_wr.pop_front();
        chk("wr_addr", {27'd0, rf_waddr_o}, {27'd0, w.a});
        chk("wr_data", rf_wdat_o, w.d);
      end
    end
    if (rf_sre_o) begin
      if (q_rd.size() == 0) chk("rd_unexpected", {27'd0, rf_sraddr_o}, 32'hFFFF_FFFF);
      else begin
        r = q_rd.pop_front();
        chk("rd_cycle", cyc, r.cyc);
        chk("rd_addr", {27'd0, rf_sraddr_o}, {27'd0, r.a});
      end
    end
    if (spr_gpr_ack_o) begin
      if (q_ack.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
      else begin
        k = q_ack.pop_front();
        chk("ack_cycle", cyc, k.cyc);
        if (k.rd) chk("ack_rdata", spr_gpr_dat_o, k.d);
      end
    end
  end

  // Caller holds rst high; the sweep starts the cycle rst drops.
  task automatic run_sweep(input int wb_at);
    int last;
    last = (wb_at >= 0) ? 32 : 31;
    for (int a = 0; a < 32; a++) begin
      if (a == wb_at) q_wr.push_back('{a: 5'd7, d: 32'hDEADBEEF});
      q_wr.push_back('{a: 5'(a), d: '0});
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k <= last + 1; k++) begin
      wb_rf_we_i   = (k == wb_at);
      wb_rfd_adr_i = 5'd7;
      wb_result_i  = 32'hDEADBEEF;
      @(negedge clk);
      chk("init_busy", {31'd0, init_busy_o}, {31'd0, (k <= last)});
      @(posedge clk); #1;
    end
    wb_rf_we_i = 1'b0;
  endtask

  // Called at posedge+1; nwb cycles of WB contention (to r9) from the strobe cycle.
  task automatic spr(input logic [15:0] addr, input logic we, input logic [DW-1:0] d,
                     input int nwb, input logic [DW-1:0] exp_rd);
    int n;
    logic got;
    logic [AW-1:0] idx;
    n   = cyc;
    got = 1'b0;
    idx = addr[AW-1:0];
    for (int i = 0; i < nwb; i++) q_wr.push_back('{a: 5'd9, d: 32'h9000_0000 + i});
    if (we) begin
      q_wr.push_back('{a: idx, d: d});
      q_ack.push_back('{cyc: n + nwb + 1, rd: 1'b0, d: '0});
    end else begin
      q_rd.push_back('{cyc: n + nwb, a: idx});
      q_ack.push_back('{cyc: n + nwb + 2, rd: 1'b1, d: exp_rd});
    end
    spr_bus_addr_i = addr;
    spr_bus_we_i   = we;
    spr_bus_dat_i  = d;
    spr_bus_stb_i  = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      wb_rf_we_i   = (i < nwb);
      wb_rfd_adr_i = 5'd9;
      wb_result_i  = 32'h9000_0000 + i;
      @(negedge clk);
      if (spr_gpr_ack_o) got = 1'b1;
      @(posedge clk); #1;
    end
    spr_bus_stb_i = 1'b0;
    wb_rf_we_i    = 1'b0;
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_we",   {31'd0, rf_we_o},       32'd0);
    chk("rst_sre",  {31'd0, rf_sre_o},      32'd0);
    chk("rst_ack",  {31'd0, spr_gpr_ack_o}, 32'd0);
    chk("rst_dat",  spr_gpr_dat_o,          32'd0);
    chk("rst_busy", {31'd0, init_busy_o},   32'd1);

    run_sweep(-1);

    rst = 1'b1;
    run_sweep(5);

    spr(16'h0403, 1'b1, 32'h12345678, 0, '0);
    spr(16'h0403, 1'b1, 32'h12345678, 2, '0);

    q_wr.push_back('{a: 5'd5, d: 32'hCAFE0001});
    wb_rf_we_i = 1'b1; wb_rfd_adr_i = 5'd5; wb_result_i = 32'hCAFE0001;
    @(posedge clk); #1 wb_rf_we_i = 1'b0;

    spr(16'h0405, 1'b0, '0, 0, 32'hCAFE0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dat_hold", spr_gpr_dat_o, 32'hCAFE0001);
      @(posedge clk); #1;
    end
    spr(16'h0403, 1'b0, '0, 1, 32'h12345678);

    spr_bus_addr_i = 16'h0800;
    spr_bus_stb_i  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      spr_bus_we_i = (i >= 3);
      @(negedge clk);
      chk("miss_we",  {31'd0, rf_we_o},       32'd0);
      chk("miss_sre", {31'd0, rf_sre_o},      32'd0);
      chk("miss_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
      @(posedge clk); #1;
    end
    spr_bus_stb_i = 1'b0;

    q_rd.push_back('{cyc: cyc, a: 5'd5});
    spr_bus_addr_i = 16'h0405; spr_bus_we_i = 1'b0; spr_bus_stb_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; spr_bus_stb_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    chk("rst_mid_we",  {31'd0, rf_we_o},       32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_ack2", {31'd0, spr_gpr_ack_o}, 32'd0);
    chk("rst_mid_busy", {31'd0, init_busy_o},   32'd1);
    run_sweep(-1);

    repeat (3) @(posedge clk);
    #1;
    chk("queues_empty", q_wr.size() + q_rd.size() + q_ack.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
